fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter granting bursts of writes from two requesters into one shared FIFO.
// Optional per-requester word counters are enabled by defining FIFO_WR_ARB_CNT_EN.
module fifo_wr_arb #(
   parameter int DW    = 8,
   parameter int BURST = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   output logic          gnt0,
   output logic          gnt1,
   input  logic          fifo_full,
   output logic          fifo_txen,
   output logic [DW-1:0] fifo_txd,
   output logic          busy,
   output logic          owner
`ifdef FIFO_WR_ARB_CNT_EN
   ,
   output logic [15:0]   cnt0,
   output logic [15:0]   cnt1
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BURST,
      S_GAP
   } state_t;

   localparam logic [7:0] LastCnt = 8'(BURST - 1);

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic [7:0] burstCnt_q, burstCnt_d;
   logic       ownerReq;
   logic       wrEn;

   assign ownerReq = owner_q ? req1 : req0;
   assign wrEn     = (state_q == S_BURST) && ownerReq && !fifo_full;

   // State register; owner resets to 1 so requester 0 wins the first contended arbitration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b1;
         burstCnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         burstCnt_q <= burstCnt_d;
      end
   end

   // Next-state logic: arbitrate in IDLE, count writes in BURST, one dead cycle in GAP.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      burstCnt_d = burstCnt_q;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               owner_d    = (req0 && req1) ? ~owner_q : req1;
               burstCnt_d = 8'd0;
               state_d    = S_BURST;
            end
         end
         S_BURST: begin
            if (wrEn) begin
               burstCnt_d = burstCnt_q + 8'd1;
               if (burstCnt_q == LastCnt) begin
                  state_d = S_GAP;
               end
            end else if (!ownerReq) begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic: data is a zero-latency mux of the owner's input, forced to 0 when idle.
   always_comb begin
      fifo_txen = wrEn;
      gnt0      = wrEn && !owner_q;
      gnt1      = wrEn && owner_q;
      fifo_txd  = '0;
      if (wrEn) begin
         fifo_txd = owner_q ? din1 : din0;
      end
      busy  = (state_q != S_IDLE);
      owner = owner_q;
   end

`ifdef FIFO_WR_ARB_CNT_EN
   logic [15:0] cnt0_q, cnt1_q;

   // Per-requester accepted-word counters, free-running with natural wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= 16'd0;
         cnt1_q <= 16'd0;
      end else begin
         if (gnt0) begin
            cnt0_q <= cnt0_q + 16'd1;
         end
         if (gnt1) begin
            cnt1_q <= cnt1_q + 16'd1;
         end
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`endif

endmodule
